// File: rtl/meas_sched_if.sv
// ---------------------------------------------------------------------------
// meas_sched_if -- bundle between the measurement scheduler and its
// environment (enable/mask control, engine handshake, status read port).
//   master : drives en, ch_en, meas_done, meas_val, rd_ch
//   slave  : the scheduler; drives ch_sel, meas_arm, upd, upd_ch,
//            sweep_done, rd_data, rd_stat
// ---------------------------------------------------------------------------
interface meas_sched_if #(
    parameter int N_CH = 4,
    parameter int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic            en;
    logic [N_CH-1:0] ch_en;
    logic [CW-1:0]   ch_sel;
    logic            meas_arm;
    logic            meas_done;
    logic [15:0]     meas_val;
    logic            upd;
    logic [CW-1:0]   upd_ch;
    logic            sweep_done;
    logic [CW-1:0]   rd_ch;
    logic [15:0]     rd_data;
    logic [2:0]      rd_stat;

    modport master (
        output en, ch_en, meas_done, meas_val, rd_ch,
        input  ch_sel, meas_arm, upd, upd_ch, sweep_done, rd_data, rd_stat
    );

    modport slave (
        input  en, ch_en, meas_done, meas_val, rd_ch,
        output ch_sel, meas_arm, upd, upd_ch, sweep_done, rd_data, rd_stat
    );
endinterface

// File: rtl/meas_sched.sv
// ---------------------------------------------------------------------------
// meas_sched -- round-robin scheduler sharing one period-measurement engine
// across N_CH channels. Each enabled channel is selected, allowed to settle,
// armed, and its result (or timeout) stored with a 3-bit status
// {timeout, range_err, ok}.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : meas_sched_if.slave (control, engine handshake, read port)
// ---------------------------------------------------------------------------
module meas_sched #(
    parameter int N_CH    = 4,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 4096,
    parameter int MIN_VAL = 830,
    parameter int MAX_VAL = 1005,
    parameter int RST_VAL = 500
) (
    input  logic         clk,
    input  logic         rst,
    meas_sched_if.slave  bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_WAIT, S_STORE} state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_ch_sel, r_last, w_pick;
    logic [N_CH-1:0] r_mask;
    logic [SW-1:0]   r_settle;
    logic [TW-1:0]   r_timer, w_timer_inc;
    logic            r_got_done;
    logic [15:0]     r_val;
    logic [15:0]     r_res  [N_CH];
    logic [2:0]      r_stat [N_CH];
    logic            w_higher;
    logic            w_in_win;
    int              w_idx;

    // Next enabled channel strictly after the last serviced one, wrapping.
    // r_last resets to N_CH-1 so the first search starts at channel 0.
    always_comb begin
        w_pick = '0;
        w_idx  = 0;
        for (int i = N_CH; i >= 1; i--) begin
            w_idx = (int'(r_last) + i) % N_CH;
            if (bus.ch_en[w_idx]) w_pick = CW'(w_idx);
        end
    end

    // Any channel above the serviced one in the mask latched at selection.
    always_comb begin
        w_higher = 1'b0;
        for (int i = 0; i < N_CH; i++)
            if (i > int'(r_ch_sel) && r_mask[i]) w_higher = 1'b1;
    end

    assign w_timer_inc = r_timer + 1'b1;
    assign w_in_win    = (r_val >= 16'(MIN_VAL)) && (r_val <= 16'(MAX_VAL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.en && |bus.ch_en) w_next = S_SELECT;
            S_SELECT: if (!bus.en) w_next = S_IDLE;
                      else if (r_settle == SW'(SETTLE - 1)) w_next = S_ARM;
            S_ARM:    w_next = bus.en ? S_WAIT : S_IDLE;
            // Done wins over timeout when both land on the same cycle.
            S_WAIT:   if (!bus.en) w_next = S_IDLE;
                      else if (bus.meas_done || w_timer_inc == TW'(TIMEOUT - 1))
                          w_next = S_STORE;
            S_STORE:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Arm is withheld when en drops in ARM so the engine is not started for
    // a measurement that will be discarded.
    assign bus.meas_arm   = (r_state == S_ARM) && bus.en;
    assign bus.upd        = (r_state == S_STORE);
    assign bus.upd_ch     = (r_state == S_STORE) ? r_ch_sel : '0;
    assign bus.sweep_done = (r_state == S_STORE) && !w_higher;
    assign bus.ch_sel     = r_ch_sel;
    assign bus.rd_data    = r_res[bus.rd_ch];
    assign bus.rd_stat    = r_stat[bus.rd_ch];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_sel   <= '0;
            r_last     <= CW'(N_CH - 1);
            r_mask     <= '0;
            r_settle   <= '0;
            r_timer    <= '0;
            r_got_done <= 1'b0;
            r_val      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_res[i]  <= 16'(RST_VAL);
                r_stat[i] <= 3'b000;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_next == S_SELECT) begin
                    r_ch_sel <= w_pick;
                    r_mask   <= bus.ch_en;
                    r_settle <= '0;
                end
                S_SELECT: r_settle <= r_settle + 1'b1;
                S_ARM:    r_timer  <= '0;
                S_WAIT: begin
                    r_got_done <= bus.meas_done;
                    if (bus.meas_done) r_val   <= bus.meas_val;
                    else               r_timer <= w_timer_inc;
                end
                S_STORE: begin
                    r_last <= r_ch_sel;
                    if (!r_got_done) begin
                        r_stat[r_ch_sel] <= 3'b100;
                    end else if (w_in_win) begin
                        r_res[r_ch_sel]  <= r_val;
                        r_stat[r_ch_sel] <= 3'b001;
                    end else begin
                        r_stat[r_ch_sel] <= 3'b010;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_meas_sched.sv
module tb_meas_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   a0, a1, n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    meas_sched_if #(.N_CH(4)) ifc ();

    meas_sched #(
        .N_CH(4), .SETTLE(8), .TIMEOUT(4096),
        .MIN_VAL(830), .MAX_VAL(1005), .RST_VAL(500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_arm(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifc.meas_arm === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("arm_timeout", 0, 1);
    endtask

    task automatic rd_chk(input int ch, input int d, input int s, input string tag);
        ifc.rd_ch = 2'(ch);
        #1;
        chk({tag, "_data"}, 32'(ifc.rd_data), d);
        chk({tag, "_stat"}, 32'(ifc.rd_stat), s);
    endtask

    // One full service: arm seen, engine answers lat cycles later, STORE and
    // read-back checked.
    task automatic svc(input int ch, input int lat, input int val, input int sw,
                       input int stat, input int res, output int at);
        wait_arm(at);
        chk("arm_ch", 32'(ifc.ch_sel), ch);
        repeat (lat) @(negedge clk);
        ifc.meas_done = 1'b1;
        ifc.meas_val  = 16'(val);
        @(negedge clk);
        ifc.meas_done = 1'b0;
        chk("upd", 32'(ifc.upd), 1);
        chk("upd_ch", 32'(ifc.upd_ch), ch);
        chk("sweep", 32'(ifc.sweep_done), sw);
        @(negedge clk);
        rd_chk(ch, res, stat, "rd");
    endtask

    initial begin
        ifc.en = 1'b0; ifc.ch_en = 4'b0000; ifc.meas_done = 1'b0;
        ifc.meas_val = 16'd0; ifc.rd_ch = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_ch_sel", 32'(ifc.ch_sel), 0);
        chk("rst_arm", 32'(ifc.meas_arm), 0);
        chk("rst_upd", 32'(ifc.upd), 0);
        chk("rst_upd_ch", 32'(ifc.upd_ch), 0);
        chk("rst_sweep", 32'(ifc.sweep_done), 0);
        for (int c = 0; c < 4; c++) rd_chk(c, 500, 0, "rst_rd");

        // Full sweep, all channels, 900 after 20 cycles
        rst = 1'b1; ifc.en = 1'b1; ifc.ch_en = 4'b1111;
        svc(0, 20, 900, 0, 1, 900, a0);
        svc(1, 20, 900, 0, 1, 900, a1);
        chk("space_all", a1 - a0, 31);
        svc(2, 20, 900, 0, 1, 900, a0);
        svc(3, 20, 900, 1, 1, 900, a0);
        svc(0, 20, 900, 0, 1, 900, a0);

        // Sparse mask: only 0 and 2, sweep on 2
        ifc.ch_en = 4'b0101;
        svc(2, 20, 900, 1, 1, 900, a0);
        svc(0, 20, 900, 0, 1, 900, a1);
        chk("space_sparse", a1 - a0, 31);
        svc(2, 20, 900, 1, 1, 900, a0);

        // Window edges and out-of-range
        ifc.ch_en = 4'b1111;
        svc(3, 20, 900, 1, 1, 900, a0);
        svc(0, 20, 830, 0, 1, 830, a0);
        svc(1, 20, 1200, 0, 2, 900, a0);

        // Engine silent on channel 2 -> timeout
        wait_arm(a0);
        chk("to_arm_ch", 32'(ifc.ch_sel), 2);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (ifc.upd === 1'b1) break;
        end
        chk("to_latency", cyc - a0, 4096);
        chk("to_upd_ch", 32'(ifc.upd_ch), 2);
        chk("to_sweep", 32'(ifc.sweep_done), 0);
        @(negedge clk);
        rd_chk(2, 900, 4, "to_rd");

        svc(3, 20, 1005, 1, 1, 1005, a0);
        svc(0, 20, 1006, 0, 2, 830, a0);

        // en dropped during WAIT on channel 1
        wait_arm(a0);
        chk("drop_arm_ch", 32'(ifc.ch_sel), 1);
        repeat (5) @(negedge clk);
        ifc.en = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.upd === 1'b1 || ifc.meas_arm === 1'b1) n++;
        end
        chk("drop_no_activity", n, 0);
        rd_chk(1, 900, 2, "drop_rd");
        ifc.en = 1'b1;
        wait_arm(a0);
        chk("rearm_ch", 32'(ifc.ch_sel), 1);

        // Reset mid-WAIT
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_arm", 32'(ifc.meas_arm), 0);
        chk("mid_rst_ch_sel", 32'(ifc.ch_sel), 0);
        for (int c = 0; c < 4; c++) rd_chk(c, 500, 0, "mid_rst_rd");
        rst = 1'b1;
        ifc.meas_done = 1'b1;
        ifc.meas_val  = 16'd900;
        @(negedge clk);
        ifc.meas_done = 1'b0;
        svc(0, 20, 900, 0, 1, 900, a0);
        rd_chk(1, 500, 0, "post_rst_rd1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
